// File: rtl/axi_dma_pkg.sv
// Shared definitions for the AXI DMA receive path: FSM state encoding, beat
// geometry, AXI response codes and the write-beat payload struct.
package axi_dma_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned CNT_W      = 8;
  localparam int unsigned BEAT_BYTES = 8;
  localparam int unsigned DATA_W     = BEAT_BYTES * 8;
  localparam int unsigned LANE_W     = 3;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } dma_state_e;

  // One write beat under construction: packed data lanes plus byte strobes.
  typedef struct packed {
    logic [DATA_W-1:0]     data;
    logic [BEAT_BYTES-1:0] strb;
  } wr_beat_t;

  // Round a byte address down to its beat boundary.
  function automatic logic [ADDR_W-1:0] beat_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:LANE_W], LANE_W'(0)};
  endfunction

endpackage

// File: rtl/axi_dma_recv.sv
// axi_dma_recv: packs a received byte stream into 8-byte AXI write beats.
//   aclk, aresetn          clock, async active-low reset
//   start/base_addr/count  transfer request (sampled on start)
//   flush                  channel ended early; write out any partial beat
//   busy/done/error        status; bytes_written counts accepted bytes
//   s_tdata/s_tvalid/s_tready  incoming byte stream
//   aw*/w*/b*              M_AXI write channels, one write outstanding at most
// Build option: AXI_DMA_RECV_ERR_ABORT_EN aborts the transfer on a non-OKAY
// write response instead of recording the error and carrying on.
module axi_dma_recv
  import axi_dma_pkg::*;
(
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [CNT_W-1:0]      count,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [CNT_W-1:0]      bytes_written,
  input  logic [7:0]            s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [ADDR_W-1:0]     awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_W-1:0]     wdata,
  output logic [BEAT_BYTES-1:0] wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  dma_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [CNT_W-1:0]  bw_q, bw_d;
  wr_beat_t          beat_q, beat_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d, tready_q, tready_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic flush_pend_q, flush_pend_d;
  logic abort;

  logic [LANE_W-1:0] lane;
  logic              aw_hs, w_hs, b_hs;

  assign lane  = addr_q[LANE_W-1:0];
  assign aw_hs = awvalid_q && awready;
  assign w_hs  = wvalid_q && wready;
  assign b_hs  = bready_q && bvalid;

  // State and output registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      awaddr_q     <= '0;
      remaining_q  <= '0;
      bw_q         <= '0;
      beat_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      tready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      awaddr_q     <= awaddr_d;
      remaining_q  <= remaining_d;
      bw_q         <= bw_d;
      beat_q       <= beat_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      tready_q     <= tready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    awaddr_d     = awaddr_q;
    remaining_d  = remaining_q;
    bw_d         = bw_q;
    beat_d       = beat_q;
    done_d       = 1'b0;
    err_d        = err_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    flush_pend_d = flush_pend_q;
    abort        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          err_d        = 1'b0;
          bw_d         = '0;
          beat_d       = '0;
          flush_pend_d = 1'b0;
          if (count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = FILL;
            addr_d      = base_addr;
            remaining_d = count;
          end
        end
      end

      FILL: begin
        // flush wins over a byte offered in the same cycle
        if (flush) begin
          if (beat_q.strb != '0) begin
            state_d      = WRITE;
            flush_pend_d = 1'b1;
            awvalid_d    = 1'b1;
            wvalid_d     = 1'b1;
            awaddr_d     = beat_align(addr_q);
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else if (s_tvalid && tready_q) begin
          beat_d.data[{lane, 3'b000} +: 8] = s_tdata;
          beat_d.strb[lane]                = 1'b1;
          addr_d      = addr_q + ADDR_W'(1);
          bw_d        = bw_q + CNT_W'(1);
          remaining_d = remaining_q - CNT_W'(1);
          // beat is complete at the top lane or on the last byte
          if (lane == LANE_W'(BEAT_BYTES - 1) || remaining_q == CNT_W'(1)) begin
            state_d   = WRITE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = beat_align(addr_q);
          end
        end
      end

      WRITE: begin
        if (flush) flush_pend_d = 1'b1;
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = RESP;
          bready_d = 1'b1;
        end
      end

      RESP: begin
        if (flush) flush_pend_d = 1'b1;
        if (b_hs) begin
          bready_d = 1'b0;
          beat_d   = '0;
          if (bresp != AXI_RESP_OKAY) err_d = 1'b1;
`ifdef AXI_DMA_RECV_ERR_ABORT_EN
          abort = (bresp != AXI_RESP_OKAY);
`endif
          if (!abort && remaining_q != '0 && !flush_pend_q && !flush) begin
            state_d = FILL;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d   = (state_d != IDLE);
    tready_d = (state_d == FILL) && (remaining_d != '0);
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = err_q;
  assign bytes_written = bw_q;
  assign s_tready      = tready_q;
  assign awaddr        = awaddr_q;
  assign awvalid       = awvalid_q;
  assign wdata         = beat_q.data;
  assign wstrb         = beat_q.strb;
  assign wvalid        = wvalid_q;
  assign bready        = bready_q;

endmodule

// File: tb/tb_axi_dma_recv.sv
// Self-checking bench for axi_dma_recv: table of transfers with a beat
// scoreboard fed by a bench-side packing model, plus hand-written sequences
// for delayed AW acceptance and reset in mid-write.
`timescale 1ns/1ps
module tb_axi_dma_recv;
  import axi_dma_pkg::*;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        start, flush;
  logic [31:0] base_addr;
  logic [7:0]  count;
  logic        busy, done, error;
  logic [7:0]  bytes_written;
  logic [7:0]  s_tdata;
  logic        s_tvalid, s_tready;
  logic [31:0] awaddr;
  logic        awvalid, awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  always #5 aclk = ~aclk;

  axi_dma_recv dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .base_addr(base_addr),
    .count(count), .flush(flush), .busy(busy), .done(done), .error(error),
    .bytes_written(bytes_written), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tready(s_tready), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    logic [31:0] awaddr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
  } beat_t;

  typedef struct {
    logic [31:0] base;
    logic [7:0]  count;
    int          nsend;
    bit          do_flush;
    int          err_beat;
    logic [7:0]  exp_bw;
    logic        exp_err;
    int          exp_beats;
  } vec_t;

  beat_t exp_q[$];
  vec_t  vecs[8];

  int n_checks = 0;
  int n_fail   = 0;

  // slave configuration and bookkeeping
  int          aw_delay = 0, w_delay = 0;
  int          cur_err_beat = -1;
  int          beat_cnt = 0;
  logic [31:0] last_awaddr;
  logic [63:0] last_wdata;
  logic [7:0]  last_wstrb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // AXI write slave + scoreboard; decisions made on the falling edge take
  // effect at the following rising edge.
  initial begin : slave
    int          aw_wait, w_wait;
    bit          got_aw, got_w, pend_b, b_fire;
    logic [31:0] cap_awaddr;
    logic [63:0] cap_wdata;
    logic [7:0]  cap_wstrb;
    logic [1:0]  nxt_resp;
    beat_t       e;
    aw_wait = 0; w_wait = 0; got_aw = 0; got_w = 0; pend_b = 0; b_fire = 0;
    nxt_resp = AXI_RESP_OKAY;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = AXI_RESP_OKAY;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        aw_wait = 0; w_wait = 0; got_aw = 0; got_w = 0; pend_b = 0; b_fire = 0;
      end else begin
        if (b_fire) begin bvalid = 1'b0; b_fire = 0; end
        if (pend_b) begin bvalid = 1'b1; bresp = nxt_resp; pend_b = 0; end
        b_fire = bvalid && bready;

        if (awvalid || wvalid || bready)
          check("tready_quiet_during_axi", 64'(s_tready), 64'(0));

        awready = awvalid && (aw_wait >= aw_delay);
        aw_wait = (awvalid && !awready) ? aw_wait + 1 : 0;
        wready  = wvalid && (w_wait >= w_delay);
        w_wait  = (wvalid && !wready) ? w_wait + 1 : 0;

        if (awvalid && awready) begin
          check("single_outstanding", 64'(got_aw || pend_b || bvalid), 64'(0));
          got_aw = 1; cap_awaddr = awaddr;
        end
        if (wvalid && wready) begin
          got_w = 1; cap_wdata = wdata; cap_wstrb = wstrb;
        end
        if (got_aw && got_w) begin
          got_aw = 0; got_w = 0;
          check("beat_expected", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("awaddr", 64'(cap_awaddr), 64'(e.awaddr));
            check("wdata",  cap_wdata,       e.wdata);
            check("wstrb",  64'(cap_wstrb),  64'(e.wstrb));
          end
          last_awaddr = cap_awaddr; last_wdata = cap_wdata; last_wstrb = cap_wstrb;
          nxt_resp = (beat_cnt == cur_err_beat) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
          beat_cnt++;
          pend_b = 1;
        end
      end
    end
  end

  // Offer one byte (called on a falling edge) and hold it until accepted.
  task automatic send_byte(input logic [7:0] b);
    int cyc = 0;
    s_tdata = b; s_tvalid = 1'b1;
    while (!s_tready && cyc < 200) begin @(negedge aclk); cyc++; end
    if (!s_tready) begin
      check("tready_timeout", 64'(s_tready), 64'(1));
      s_tvalid = 1'b0;
      return;
    end
    @(negedge aclk);
    s_tvalid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic [7:0] ebw, input logic eerr);
    int cyc = 0;
    while (!done && cyc < 500) begin @(negedge aclk); cyc++; end
    check({tag, "_done"}, 64'(done), 64'(1));
    check({tag, "_bytes_written"}, 64'(bytes_written), 64'(ebw));
    check({tag, "_error"}, 64'(error), 64'(eerr));
  endtask

  // Reference packing: bytes i+1 at consecutive addresses, beat closes at lane 7
  // or after the last byte sent.
  task automatic push_model(input logic [31:0] base, input int nsend);
    logic [31:0] a;
    int          lane;
    beat_t       b;
    a = base;
    b.awaddr = '0; b.wdata = '0; b.wstrb = '0;
    for (int i = 0; i < nsend; i++) begin
      lane = int'(a[2:0]);
      if (b.wstrb == 8'h00) b.awaddr = {a[31:3], 3'b000};
      b.wdata[lane*8 +: 8] = 8'(i + 1);
      b.wstrb[lane] = 1'b1;
      a = a + 32'd1;
      if (lane == 7 || i == nsend - 1) begin
        exp_q.push_back(b);
        b.awaddr = '0; b.wdata = '0; b.wstrb = '0;
      end
    end
  endtask

  task automatic run_xfer(input vec_t v, input string tag);
    push_model(v.base, v.nsend);
    beat_cnt = 0;
    cur_err_beat = v.err_beat;
    base_addr = v.base; count = v.count; start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'(v.count != 8'd0));
    for (int i = 0; i < v.nsend; i++) send_byte(8'(i + 1));
    if (v.do_flush) begin
      flush = 1'b1;
      @(negedge aclk);
      flush = 1'b0;
    end
    wait_done(tag, v.exp_bw, v.exp_err);
    @(negedge aclk);
    check({tag, "_done_one_cycle"}, 64'(done), 64'(0));
    check({tag, "_idle_busy"}, 64'(busy), 64'(0));
    check({tag, "_beats"}, 64'(beat_cnt), 64'(v.exp_beats));
    check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t hv;
    bit   done_seen;
    int   cyc;

    aresetn = 1'b0; start = 1'b0; flush = 1'b0; base_addr = '0; count = '0;
    s_tdata = '0; s_tvalid = 1'b0;

    //          base          cnt   nsend flush err  bw     err   beats
    vecs[0] = '{32'h0000_1000, 8'd8,  8,  1'b0, -1, 8'd8,  1'b0, 1};
    vecs[1] = '{32'h0000_1005, 8'd5,  5,  1'b0, -1, 8'd5,  1'b0, 2};
    vecs[2] = '{32'h0000_2000, 8'd4,  2,  1'b1, -1, 8'd2,  1'b0, 1};
`ifdef AXI_DMA_RECV_ERR_ABORT_EN
    vecs[3] = '{32'h0000_3000, 8'd16, 8,  1'b0,  0, 8'd8,  1'b1, 1};
`else
    vecs[3] = '{32'h0000_3000, 8'd16, 16, 1'b0,  0, 8'd16, 1'b1, 2};
`endif
    vecs[4] = '{32'h0000_4003, 8'd3,  3,  1'b0, -1, 8'd3,  1'b0, 1};
    vecs[5] = '{32'h0000_5000, 8'd0,  0,  1'b0, -1, 8'd0,  1'b0, 0};
    vecs[6] = '{32'h0000_6000, 8'd4,  0,  1'b1, -1, 8'd0,  1'b0, 0};
    vecs[7] = '{32'h0000_7007, 8'd2,  2,  1'b0, -1, 8'd2,  1'b0, 2};

    repeat (3) @(negedge aclk);
    check("reset_ctrl", 64'({busy, done, error, s_tready, awvalid, wvalid, bready}), 64'(0));
    check("reset_data", wdata, 64'(0));
    check("reset_addr_strb_bw", 64'({awaddr, wstrb, bytes_written}), 64'(0));
    aresetn = 1'b1;
    @(negedge aclk);
    check("idle_after_reset", 64'({busy, done, s_tready, awvalid, wvalid, bready}), 64'(0));

    for (int i = 0; i < 8; i++) begin
      run_xfer(vecs[i], $sformatf("vec%0d", i));
      if (i == 0) begin
        check("vec0_awaddr", 64'(last_awaddr), 64'(32'h0000_1000));
        check("vec0_wstrb",  64'(last_wstrb),  64'(8'hFF));
        check("vec0_wdata",  last_wdata,       64'h0807_0605_0403_0201);
      end
    end

    // AW accepted three cycles after W
    aw_delay = 3;
    hv = '{32'h0000_8000, 8'd8, 8, 1'b0, -1, 8'd8, 1'b0, 1};
    run_xfer(hv, "aw_late");
    aw_delay = 0;

    // Reset while the beat is stuck in WRITE
    aw_delay = 20;
    beat_cnt = 0; cur_err_beat = -1;
    base_addr = 32'h0000_9000; count = 8'd8; start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(8'(8'h40 + i));
    cyc = 0;
    while (!awvalid && cyc < 20) begin @(negedge aclk); cyc++; end
    check("rst_mid_awvalid", 64'(awvalid), 64'(1));
    #2 aresetn = 1'b0;
    #1;
    check("rst_mid_ctrl", 64'({busy, done, error, s_tready, awvalid, wvalid, bready}), 64'(0));
    check("rst_mid_data", wdata, 64'(0));
    check("rst_mid_addr_strb_bw", 64'({awaddr, wstrb, bytes_written}), 64'(0));
    done_seen = 0;
    repeat (3) begin @(negedge aclk); if (done) done_seen = 1; end
    #2 aresetn = 1'b1;
    aw_delay = 0;
    exp_q.delete();
    repeat (3) begin @(negedge aclk); if (done) done_seen = 1; end
    check("rst_mid_no_done", 64'(done_seen), 64'(0));
    hv = '{32'h0000_A002, 8'd6, 6, 1'b0, -1, 8'd6, 1'b0, 1};
    run_xfer(hv, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_dma_recv.md
AXI_DMA_RECV -- requirements
Module: axi_dma_recv

Interface
REQ-001 SHALL have port aclk, input, 1: sole clock; all logic on rising edge.
REQ-002 SHALL have port aresetn, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1: one-cycle pulse that begins a transfer.
REQ-004 SHALL have port base_addr, input, 32: first byte address, sampled on start.
REQ-005 SHALL have port count, input, 8: byte count, sampled on start.
REQ-006 SHALL have port flush, input, 1: pulse that ends the transfer early (channel ended before count).
REQ-007 SHALL have port busy, output, 1: high from the cycle after start until done.
REQ-008 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-009 SHALL have port error, output, 1: sticky while any BRESP was not OKAY; cleared on start.
REQ-010 SHALL have port bytes_written, output, 8: bytes accepted in the current or last transfer.
REQ-011 SHALL have ports s_tdata, input, 8; s_tvalid, input, 1; s_tready, output, 1: received-byte stream from the channel.
REQ-012 SHALL have the M_AXI write channels: awaddr, output, 32; awvalid, output, 1; awready, input, 1; wdata, output, 64; wstrb, output, 8; wvalid, output, 1; wready, input, 1; bresp, input, 2; bvalid, input, 1; bready, output, 1.

Function
REQ-013 SHALL use states IDLE, FILL, WRITE, RESP; the FSM SHALL ignore start outside IDLE.
REQ-014 SHALL move IDLE->FILL on start with count!=0: latch addr=base_addr and remaining=count, clear strb/data/bytes_written/error.
REQ-015 SHALL treat start with count==0 as an empty transfer: pulse done the next cycle, no AXI traffic, busy stays low.
REQ-016 SHALL assert s_tready only in FILL with remaining!=0; a byte is accepted on s_tvalid&&s_tready.
REQ-017 SHALL, on each accepted byte, place it in lane L=addr[2:0] (wdata[8L+7:8L]), set wstrb[L], increment addr and bytes_written, and decrement remaining.
REQ-018 SHALL go FILL->WRITE when the accepted byte has L==7 or makes remaining 0; awvalid and wvalid SHALL assert the next cycle.
REQ-019 SHALL drive awaddr={addr_of_beat[31:3],3'b000} so it is 8-byte aligned.
REQ-020 SHALL give flush in FILL priority over a simultaneous byte: that byte is not accepted. If wstrb!=0, go to WRITE and end after RESP; if wstrb==0, pulse done next cycle.
REQ-021 SHALL complete the AW and W handshakes independently, dropping each valid on its own handshake; the FSM SHALL go WRITE->RESP once both are done.
REQ-022 SHALL hold bready high in RESP and set error if bresp!=2'b00 on the B handshake.
REQ-023 SHALL, after the B handshake, clear the beat and return to FILL if remaining!=0 and no flush is pending; otherwise return to IDLE and pulse done the next cycle.
REQ-024 SHALL latch a flush that arrives in WRITE or RESP and apply it at the B handshake.
REQ-025 SHALL never issue more than one outstanding AXI write.

Reset
REQ-026 SHALL, on assertion of aresetn=0, immediately force state IDLE and drive busy, done, error, s_tready, awvalid, wvalid, bready, wstrb, wdata, awaddr and bytes_written to 0.
REQ-027 SHALL, on reset in mid-transfer, abandon the transfer without a done pulse.

Configuration
REQ-028 SHALL abort the transfer when AXI_DMA_RECV_ERR_ABORT_EN is defined and a non-OKAY bresp occurs: go to IDLE, pulse done with error=1, and accept no further bytes.
REQ-029 SHALL, without AXI_DMA_RECV_ERR_ABORT_EN, record error and continue the transfer to completion.

Structure
REQ-030 SHALL take the state enum, BEAT_BYTES=8 and the AXI_RESP_OKAY/AXI_RESP_SLVERR constants from shared package axi_dma_pkg.
REQ-031 SHALL implement lane packing inline; no sub-module SHALL be used.

Verification
REQ-032 SHALL check: base_addr=0x1000, count=8, bytes 0x01..0x08 -> one write, awaddr=0x1000, wstrb=0xFF, wdata=0x0807060504030201, done, bytes_written=8.
REQ-033 SHALL check: base_addr=0x1005, count=5 -> two writes: awaddr 0x1000/wstrb 0xE0, then awaddr 0x1008/wstrb 0x03.
REQ-034 SHALL check: count=4, flush after 2 bytes at base 0x2000 -> one write, wstrb=0x03, done, bytes_written=2.
REQ-035 SHALL check: awready delayed 3 cycles after wready -> single write, s_tready low until B handshake.
REQ-036 SHALL check: bresp=SLVERR on the first of two beats -> error=1; aborts after the first beat with the macro, completes both beats without it.
REQ-037 SHALL check: aresetn low during WRITE -> all outputs 0 immediately, no done pulse; a subsequent start behaves normally.
